sha256_k_sched: RTL and testbench
=================================

# sha256_k_sched

Parametrised, registered SHA-256 round-constant sequencer for unfolded compression datapaths. It delivers UNFOLD consecutive K constants per cycle, K[t] through K[t+UNFOLD-1], and steps t through one 64-round block under a start/advance handshake. Completion is flagged back to the control FSM. It sits between the block controller and the unfolded round pipeline and replaces the fixed two-lane combinational constant lookup.

## Interface
- UNFOLD, default 2: constants delivered per cycle. Legal values are 1, 2, 4 and 8, since the value must divide 64. Any other value is an elaboration error.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a new block at round 0.
- advance  in  1  the consumer has taken the current constant group.
- k_out  out  32*UNFOLD  constant group. Lane i occupies bits [32*i+31:32*i] and carries K[round+i].
- round  out  6  index of lane 0.
- k_valid  out  1  k_out and round are valid.
- last  out  1  the current group is the final one (round == 64-UNFOLD).
- busy  out  1  a block is in progress.
- done  out  1  single-cycle pulse after the final group is consumed.

## Operation
- States: IDLE and RUN.
- IDLE:
  - k_valid=0, busy=0.
  - advance is ignored.
  - start moves the block to RUN with round=0.
- RUN:
  - k_valid=1, busy=1.
  - k_out holds K[round..round+UNFOLD-1] until advance is sampled high.
  - advance with last=0: round += UNFOLD.
  - advance with last=1: go to IDLE, pulse done, round returns to 0.
- start in RUN: abort and restart at round 0. No done pulse is produced.
- start and advance in the same cycle: start wins, including when last=1. No done pulse.
- Arithmetic: round is 6-bit unsigned. Because UNFOLD divides 64, round+UNFOLD-1 ≤ 63, so lane indices never wrap and need no default case.
- last is decoded from round alone. It is a registered output, not a combinational function of advance.

## Timing
- Reset values: k_out=0, round=0, k_valid=0, last=0, busy=0, done=0. Reset overrides start and advance, and takes effect in the cycle it is sampled, including mid-block.
- Latency: start sampled in cycle N gives k_valid=1, round=0, k_out=K[0..UNFOLD-1] in cycle N+1.
- Throughput: advance held high steps one group per cycle. A block takes 64/UNFOLD valid cycles.
- advance sampled in cycle M updates k_out and round in cycle M+1.
- Final group: advance with last=1 in cycle M gives, in cycle M+1:
  - k_valid=0, busy=0, last=0, done=1;
  - k_out cleared to 0.
- done is high for exactly one cycle.
- A start in the done cycle is legal and begins a new block the next cycle.
- Stalls: while advance=0, every output holds its value.

## Structure
- Shared package sha256_pkg holds:
  - SHA256_ROUNDS=64;
  - the 64×32-bit K table as a localparam array;
  - the state enum {IDLE, RUN}.
  
  The same table is reused by the message scheduler testbench model.
- Sub-module sha256_k_rom: a single-lane combinational lookup (6-bit index in, 32-bit K out) reading the package table. It is instantiated UNFOLD times through generate, with index round_next+i.
- Output registers are fed from the next-state round, so k_out is fully registered with no combinational path from the ROM to the output.

## Test plan
- UNFOLD=2, reset then start: the next cycle gives k_out={32'h71374491, 32'h428a2f98}, round=0, k_valid=1, last=0.
- UNFOLD=2, advance held high: 32 valid groups. Group 31 is {32'hc67178f2, 32'hbef9a3f7} with round=62 and last=1. One cycle later done=1, k_valid=0, busy=0. done then deasserts.
- UNFOLD=2, advance toggling pseudo-randomly: outputs hold during stalls. The sequence of groups matches the reference table with no skips or repeats.
- UNFOLD=2, start asserted at round=20 (with and without a simultaneous advance): the next cycle gives round=0 and k_out lane 0 = 32'h428a2f98. No done pulse.
- UNFOLD=2, rst asserted at round=40 during RUN: the next cycle shows all outputs at their reset values. A subsequent advance is ignored.
- UNFOLD=4 and UNFOLD=1:
  - UNFOLD=4 first group lanes are 428a2f98, 71374491, b5c0fbcf, e9b5dba5;
  - UNFOLD=1 final group is round=63, k_out=32'hc67178f2, last=1;
  - UNFOLD=3 fails elaboration.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round count, K constant table and the sequencer state type.
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/sha256_k_rom.sv
// Single-lane combinational K lookup: round index in, 32-bit constant out.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_k_sched.sv
// Registered SHA-256 round-constant sequencer delivering UNFOLD consecutive K values per cycle.
//
// Handshake: k_valid is high for every cycle of a block; the group on k_out (lanes
// K[round..round+UNFOLD-1]) is held until advance is sampled high, at which point the
// next group appears the following cycle. start always wins over advance and restarts at 0.
module sha256_k_sched
  import sha256_pkg::*;
#(
  parameter int UNFOLD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  advance,
  output logic [32*UNFOLD-1:0]  k_out,
  output logic [5:0]            round,
  output logic                  k_valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [5:0] STEP       = 6'(UNFOLD);
  localparam logic [5:0] LAST_ROUND = 6'(SHA256_ROUNDS - UNFOLD);

  generate
    if (UNFOLD != 1 && UNFOLD != 2 && UNFOLD != 4 && UNFOLD != 8) begin : g_bad_unfold
      $error("sha256_k_sched: UNFOLD must be 1, 2, 4 or 8");
    end
  endgenerate

  state_t     state;
  state_t     state_next;
  logic [5:0] round_next;
  logic       done_next;
  logic [32*UNFOLD-1:0] k_group;

  always_comb begin
    state_next = state;
    round_next = round;
    done_next  = 1'b0;
    if (start) begin
      state_next = RUN;
      round_next = '0;
    end else if (state == RUN && advance) begin
      if (last) begin
        state_next = IDLE;
        round_next = '0;
        done_next  = 1'b1;
      end else begin
        round_next = round + STEP;
      end
    end
  end

  // ROM lanes look ahead at the next round so k_out can be a plain register.
  for (genvar i = 0; i < UNFOLD; i++) begin : g_lane
    sha256_k_rom u_rom (
      .idx (round_next + 6'(i)),
      .k   (k_group[32*i +: 32])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round   <= '0;
      k_out   <= '0;
      k_valid <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      round   <= round_next;
      k_out   <= (state_next == RUN) ? k_group : '0;
      k_valid <= (state_next == RUN);
      busy    <= (state_next == RUN);
      last    <= (state_next == RUN) && (round_next == LAST_ROUND);
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_sha256_k_sched.sv
// Bench for sha256_k_sched: three instances (UNFOLD 2, 4, 1) checked every cycle against a round-counter model.
module tb_sha256_k_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic advance = 1'b0;

  always #5 clk = ~clk;

  logic [63:0]  k2;
  logic [127:0] k4;
  logic [31:0]  k1;
  logic [5:0]   round2, round4, round1;
  logic         valid2, valid4, valid1;
  logic         last2, last4, last1;
  logic         busy2, busy4, busy1;
  logic         done2, done4, done1;

  sha256_k_sched #(.UNFOLD(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .advance(advance),
    .k_out(k2), .round(round2), .k_valid(valid2), .last(last2), .busy(busy2), .done(done2));
  sha256_k_sched #(.UNFOLD(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .advance(advance),
    .k_out(k4), .round(round4), .k_valid(valid4), .last(last4), .busy(busy4), .done(done4));
  sha256_k_sched #(.UNFOLD(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .advance(advance),
    .k_out(k1), .round(round1), .k_valid(valid1), .last(last1), .busy(busy1), .done(done1));

  // Independent copy of the FIPS 180-4 constants.
  logic [31:0] kt [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int uf [3] = '{2, 4, 1};
  bit m_run  [3];
  int m_round[3];
  bit m_done [3];

  int checks = 0;
  int errors = 0;
  int valid_cnt2 = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] exp_kout(input int d);
    logic [255:0] r = '0;
    if (m_run[d])
      for (int i = 0; i < uf[d]; i++) r[32*i +: 32] = kt[m_round[d] + i];
    return r;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit a);
    for (int d = 0; d < 3; d++) begin
      m_done[d] = 1'b0;
      if (r) begin
        m_run[d] = 1'b0; m_round[d] = 0;
      end else if (s) begin
        m_run[d] = 1'b1; m_round[d] = 0;
      end else if (m_run[d] && a) begin
        if (m_round[d] == 64 - uf[d]) begin
          m_run[d] = 1'b0; m_round[d] = 0; m_done[d] = 1'b1;
        end else begin
          m_round[d] += uf[d];
        end
      end
    end
  endtask

  task automatic check_all();
    logic [255:0] ko [3];
    logic [5:0]  ro [3];
    logic [3:0]  fl [3];
    ko[0] = 256'(k2); ko[1] = 256'(k4); ko[2] = 256'(k1);
    ro[0] = round2;    ro[1] = round4;  ro[2] = round1;
    fl[0] = {valid2, last2, busy2, done2};
    fl[1] = {valid4, last4, busy4, done4};
    fl[2] = {valid1, last1, busy1, done1};
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("u%0d k_out", uf[d]), ko[d], exp_kout(d));
      check_eq($sformatf("u%0d round", uf[d]), 256'(ro[d]), 256'(m_round[d]));
      check_eq($sformatf("u%0d k_valid", uf[d]), 256'(fl[d][3]), 256'(m_run[d]));
      check_eq($sformatf("u%0d last", uf[d]), 256'(fl[d][2]),
               256'(m_run[d] && m_round[d] == 64 - uf[d]));
      check_eq($sformatf("u%0d busy", uf[d]), 256'(fl[d][1]), 256'(m_run[d]));
      check_eq($sformatf("u%0d done", uf[d]), 256'(fl[d][0]), 256'(m_done[d]));
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit a);
    rst = r; start = s; advance = a;
    @(posedge clk);
    model_step(r, s, a);
    #1;
    check_all();
    if (valid2) valid_cnt2++;
  endtask

  initial begin
    logic [63:0]  exp2;
    logic [127:0] exp4;

    cycle(1, 0, 0);
    cycle(1, 1, 1);
    cycle(0, 0, 1);

    // First group after start.
    cycle(0, 1, 0);
    exp2 = {32'h71374491, 32'h428a2f98};
    exp4 = {32'he9b5dba5, 32'hb5c0fbcf, 32'h71374491, 32'h428a2f98};
    check_eq("u2 first group", 256'(k2), 256'(exp2));
    check_eq("u4 first group", 256'(k4), 256'(exp4));
    check_eq("u2 first last", 256'(last2), 256'(0));

    // Advance held high through a full UNFOLD=2 block.
    valid_cnt2 = 1;
    for (int i = 0; i < 31; i++) cycle(0, 0, 1);
    exp2 = {32'hc67178f2, 32'hbef9a3f7};
    check_eq("u2 final group", 256'(k2), 256'(exp2));
    check_eq("u2 final round", 256'(round2), 256'(62));
    check_eq("u2 final last", 256'(last2), 256'(1));
    cycle(0, 0, 1);
    check_eq("u2 done pulse", 256'({done2, valid2, busy2}), 256'(3'b100));
    check_eq("u2 valid cycles", 256'(valid_cnt2), 256'(32));
    cycle(0, 0, 0);
    check_eq("u2 done drop", 256'(done2), 256'(0));

    // Full UNFOLD=1 block, checking its final group.
    cycle(0, 1, 0);
    for (int i = 0; i < 63; i++) cycle(0, 0, 1);
    check_eq("u1 final k", 256'(k1), 256'(32'hc67178f2));
    check_eq("u1 final round", 256'(round1), 256'(63));
    check_eq("u1 final last", 256'(last1), 256'(1));
    cycle(0, 1, 1);

    // Restart at round 20, without then with a simultaneous advance.
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    cycle(0, 1, 0);
    check_eq("u2 restart lane0", 256'(k2[31:0]), 256'(32'h428a2f98));
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    cycle(0, 1, 1);
    check_eq("u2 restart adv round", 256'(round2), 256'(0));

    // Reset mid-block at round 40, then an ignored advance.
    for (int i = 0; i < 20; i++) cycle(0, 0, 1);
    check_eq("u2 at 40", 256'(round2), 256'(40));
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Randomised stalls, restarts and rare resets.
    cycle(0, 1, 0);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
